scalar_mem_stage: RTL and testbench

//  Scalar memory-access stage downstream of scalar ALU execute. Takes the 36-bit ALU result
//  (address or value), store data, dest reg and ALU flags; performs load/store over a req/ack

---
 rtl/scalar_mem_stage.sv | 134 +++++++++++++
 tb/tb_scalar_mem_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mem_stage.sv
// Scalar memory-access stage: passes ALU results through or runs one load/store over a
// req/ack memory port, then presents a single registered writeback entry.
module scalar_mem_stage #(
    parameter int DATA_W   = 36,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_wb_en,
    input  logic [2:0]        in_flags,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_en,
    output logic [2:0]        wb_flags,
    output logic              mem_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               kill;
    logic [REG_W-1:0]   hold_rd;
    logic               hold_en;
    logic [2:0]         hold_flags;

    logic accept;
    logic is_mem;
    logic timeout;
    logic load_done;

    assign in_ready  = (state == IDLE) && !flush && (!wb_valid || wb_ready);
    assign accept    = in_valid && in_ready;
    assign is_mem    = (in_op == 2'b01) || (in_op == 2'b10);
    assign timeout   = !mem_ack && (wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign load_done = mem_ack && !mem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            kill       <= 1'b0;
            hold_rd    <= '0;
            hold_en    <= 1'b0;
            hold_flags <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_rd      <= '0;
            wb_en      <= 1'b0;
            wb_flags   <= '0;
            mem_err    <= 1'b0;
        end else begin
            if (wb_valid && wb_ready) begin
                wb_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (flush) begin
                        wb_valid <= 1'b0;
                    end else if (accept) begin
                        if (is_mem) begin
                            mem_req    <= 1'b1;
                            mem_we     <= (in_op == 2'b10);
                            mem_addr   <= in_alu;
                            mem_wdata  <= in_sdata;
                            hold_rd    <= in_rd;
                            hold_en    <= in_wb_en;
                            hold_flags <= in_flags;
                            wait_cnt   <= '0;
                            kill       <= 1'b0;
                            state      <= MEM_WAIT;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_data  <= in_alu;
                            wb_rd    <= in_rd;
                            wb_en    <= in_wb_en;
                            wb_flags <= in_flags;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack || timeout) begin
                        mem_req <= 1'b0;
                        kill    <= 1'b0;
                        state   <= IDLE;
                        if (!mem_ack) begin
                            mem_err <= 1'b1;
                        end
                        // A flush seen now or earlier in the wait discards the result.
                        if (!(kill || flush)) begin
                            wb_valid <= 1'b1;
                            wb_data  <= load_done ? mem_rdata : mem_addr;
                            wb_rd    <= hold_rd;
                            wb_en    <= load_done && hold_en;
                            wb_flags <= hold_flags;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (flush) begin
                            kill <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_mem_stage.sv
// Randomised scoreboard bench for scalar_mem_stage: the stimulus side predicts each
// writeback entry from the op rules, a monitor pops and compares on every consumed entry.
module tb_scalar_mem_stage;

    localparam int DATA_W   = 36;
    localparam int REG_W    = 5;
    localparam int MAX_WAIT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_sdata;
    logic [REG_W-1:0]  in_rd;
    logic              in_wb_en;
    logic [2:0]        in_flags;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [REG_W-1:0]  wb_rd;
    logic              wb_en;
    logic [2:0]        wb_flags;
    logic              mem_err;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rd;
        logic              en;
        logic [2:0]        flags;
        bit                chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   ready_mode = 1;

    scalar_mem_stage #(
        .DATA_W   (DATA_W),
        .REG_W    (REG_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_alu    (in_alu),
        .in_sdata  (in_sdata),
        .in_rd     (in_rd),
        .in_wb_en  (in_wb_en),
        .in_flags  (in_flags),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .wb_en     (wb_en),
        .wb_flags  (wb_flags),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Writeback-side readiness: 0 = stall, 1 = always ready, otherwise random.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       wb_ready = 1'b0;
            1:       wb_ready = 1'b1;
            default: wb_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: every entry the WB stage consumes must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_wb actual=entry data=%h required=no entry", wb_data);
            end else begin
                e = exp_q.pop_front();
                if (e.chk_data) checkOutput("wb_data", wb_data, e.data);
                checkOutput("wb_rd", wb_rd, e.rd);
                checkOutput("wb_en", wb_en, e.en);
                checkOutput("wb_flags", wb_flags, e.flags);
            end
        end
    end

    // Issue one entry; for memory ops also play the memory side.
    // ack_delay: req cycle (0 = first) in which ack is returned, negative = never.
    task automatic applyStimulus(input logic [1:0] op, input logic [DATA_W-1:0] alu,
                                 input logic [DATA_W-1:0] sdata, input logic [DATA_W-1:0] rdata,
                                 input logic [REG_W-1:0] rd, input logic en,
                                 input logic [2:0] flags, input int ack_delay,
                                 input bit flush_mid);
        int   guard;
        bit   is_mem;
        exp_t e;
        is_mem = (op == 2'b01) || (op == 2'b10);
        @(negedge clk);
        in_op    = op;
        in_alu   = alu;
        in_sdata = sdata;
        in_rd    = rd;
        in_wb_en = en;
        in_flags = flags;
        in_valid = 1'b1;
        guard    = 0;
        forever begin
            #1;
            if (in_ready) break;
            guard++;
            if (guard > 200) begin
                checkOutput("accept_bound", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (!is_mem) begin
            e.data = alu; e.rd = rd; e.en = en; e.flags = flags; e.chk_data = 1'b1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < MAX_WAIT + 2; c++) begin
            @(negedge clk);
            checkOutput("mem_req_held", mem_req, 1);
            checkOutput("in_ready_busy", in_ready, 0);
            if (c == 0) begin
                checkOutput("mem_we", mem_we, (op == 2'b10));
                checkOutput("mem_addr", mem_addr, alu);
                checkOutput("mem_wdata", mem_wdata, sdata);
            end
            flush = flush_mid && (c == 0);
            if (c == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                if (!flush_mid) begin
                    e.data  = (op == 2'b01) ? rdata : alu;
                    e.rd    = rd;
                    e.en    = (op == 2'b01) ? en : 1'b0;
                    e.flags = flags;
                    e.chk_data = 1'b1;
                    exp_q.push_back(e);
                end
                @(negedge clk);
                mem_ack = 1'b0;
                flush   = 1'b0;
                checkOutput("mem_req_drop_ack", mem_req, 0);
                return;
            end
            if (ack_delay < 0 && c == MAX_WAIT - 1) begin
                if (!flush_mid) begin
                    e.data = alu; e.rd = rd; e.en = 1'b0; e.flags = flags; e.chk_data = 1'b0;
                    exp_q.push_back(e);
                end
                @(negedge clk);
                flush = 1'b0;
                checkOutput("mem_req_drop_timeout", mem_req, 0);
                checkOutput("mem_err_set", mem_err, 1);
                mem_ack   = 1'b1;
                mem_rdata = ~rdata;
                @(negedge clk);
                mem_ack = 1'b0;
                return;
            end
        end
        checkOutput("mem_loop_bound", 0, 1);
    endtask

    initial begin
        logic [1:0]        op;
        int                dly;
        bit                fl;
        logic [DATA_W-1:0] r_alu;
        logic [DATA_W-1:0] r_sd;
        logic [DATA_W-1:0] r_rd;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_alu    = '0;
        in_sdata  = '0;
        in_rd     = '0;
        in_wb_en  = 1'b0;
        in_flags  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_mem_err", mem_err, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        // Back-to-back passes, including the reserved op.
        applyStimulus(2'b00, 36'h0_0000_0ABC, '0, '0, 5'd3, 1'b1, 3'b001, 0, 1'b0);
        applyStimulus(2'b00, 36'hF_0000_0001, '0, '0, 5'd31, 1'b0, 3'b110, 0, 1'b0);
        applyStimulus(2'b11, 36'h1_2345_6789, '0, '0, 5'd0, 1'b1, 3'b010, 0, 1'b0);
        applyStimulus(2'b00, 36'h0_0000_0000, '0, '0, 5'd17, 1'b1, 3'b100, 0, 1'b0);

        applyStimulus(2'b01, 36'h100, '0, 36'hF_FFFF_FFFF, 5'd7, 1'b1, 3'b010, 2, 1'b0);
        applyStimulus(2'b10, 36'h40, 36'h55, 36'h0, 5'd9, 1'b1, 3'b100, 0, 1'b0);

        // Held entry under a 4-cycle stall.
        ready_mode = 0;
        repeat (2) @(negedge clk);
        applyStimulus(2'b00, 36'h1_2345_6789, '0, '0, 5'd12, 1'b1, 3'b011, 0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("stall_wb_valid", wb_valid, 1);
            checkOutput("stall_wb_data", wb_data, 36'h1_2345_6789);
            checkOutput("stall_wb_rd", wb_rd, 12);
            checkOutput("stall_in_ready", in_ready, 0);
        end
        ready_mode = 1;
        applyStimulus(2'b00, 36'h2222, '0, '0, 5'd13, 1'b1, 3'b000, 0, 1'b0);

        applyStimulus(2'b01, 36'h300, '0, 36'h5A5, 5'd4, 1'b1, 3'b111, -1, 1'b0);

        applyStimulus(2'b01, 36'h500, '0, 36'h777, 5'd6, 1'b1, 3'b001, 3, 1'b1);
        checkOutput("kill_no_wb", wb_valid, 0);
        applyStimulus(2'b10, 36'h600, 36'h88, 36'h0, 5'd8, 1'b1, 3'b010, 0, 1'b1);
        checkOutput("kill_same_cycle_no_wb", wb_valid, 0);

        // Flush in IDLE discards a held entry.
        ready_mode = 0;
        repeat (2) @(negedge clk);
        applyStimulus(2'b00, 36'h999, '0, '0, 5'd2, 1'b1, 3'b101, 0, 1'b0);
        @(negedge clk);
        checkOutput("held_before_flush", wb_valid, 1);
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", in_ready, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_clears_wb", wb_valid, 0);
        ready_mode = 1;

        // Reset in the middle of a load; the late ack must be ignored.
        repeat (2) @(negedge clk);
        in_op    = 2'b01;
        in_alu   = 36'hABC0;
        in_rd    = 5'd1;
        in_wb_en = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("pre_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_mem_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_mem_req", mem_req, 0);
        checkOutput("rst_clears_err", mem_err, 0);
        mem_ack   = 1'b1;
        mem_rdata = 36'h1111;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("rst_late_ack_wb", wb_valid, 0);
        checkOutput("rst_late_ack_req", mem_req, 0);

        // Randomised traffic with random WB back-pressure.
        ready_mode = 2;
        repeat (60) begin
            op    = 2'($urandom_range(0, 3));
            r_alu = {4'($urandom), 32'($urandom)};
            r_sd  = {4'($urandom), 32'($urandom)};
            r_rd  = {4'($urandom), 32'($urandom)};
            dly   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            fl    = ($urandom_range(0, 7) == 0);
            applyStimulus(op, r_alu, r_sd, r_rd, 5'($urandom), 1'($urandom),
                          3'($urandom), dly, fl);
        end

        ready_mode = 1;
        repeat (6) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
